// File: rtl/fb_dot_writer.sv
`default_nettype none
// ============================================================================
// Module   : fb_dot_writer
// Summary  : Turns line-draw dots into single-beat framebuffer pixel writes.
//            Dots are clipped to the screen, queued in a small FIFO and
//            written as row*SCREEN_WIDTH+col with strobe/ack handshaking.
//            Define FB_DOT_WRITER_CLEAR_EN to add the clear-screen sequencer
//            (clear_i, CLEAR state) that zero-fills the framebuffer.
// Revision : 1.0 - initial release
// ============================================================================
module fb_dot_writer #(
  parameter int unsigned SCREEN_WIDTH  = 100,
  parameter int unsigned SCREEN_HEIGHT = 50,
  parameter int unsigned COORD_SZ      = 16,
  parameter int unsigned ADR_SZ        = 13,
  parameter int unsigned PIXEL_SZ      = 1,
  parameter int unsigned FIFO_DEPTH    = 4
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [COORD_SZ-1:0] dot_row_i,
  input  logic [COORD_SZ-1:0] dot_col_i,
  input  logic                dot_valid_i,
  input  logic                clear_i,
  output logic                mem_stb_o,
  output logic [ADR_SZ-1:0]   mem_adr_o,
  output logic [PIXEL_SZ-1:0] mem_dat_o,
  input  logic                mem_ack_i,
  output logic                busy_o,
  output logic                clipped_o,
  output logic                overflow_o
);

  localparam int unsigned           c_PTR_W    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned           c_CNT_W    = c_PTR_W + 1;
  localparam logic [COORD_SZ-1:0]   c_SCR_W    = COORD_SZ'(SCREEN_WIDTH);
  localparam logic [COORD_SZ-1:0]   c_SCR_H    = COORD_SZ'(SCREEN_HEIGHT);
  localparam logic [ADR_SZ-1:0]     c_PIX_LAST = ADR_SZ'(SCREEN_WIDTH * SCREEN_HEIGHT - 1);
  localparam logic [c_CNT_W-1:0]    c_FULL     = c_CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_CLEAR = 2'd2
  } state_t;

  state_t              r_state, w_state_nxt;
  logic                r_stb, w_stb_nxt;
  logic [ADR_SZ-1:0]   r_adr, w_adr_nxt;
  logic [PIXEL_SZ-1:0] r_dat, w_dat_nxt;
  logic                r_clipped;
  logic                r_overflow;

  logic [COORD_SZ-1:0] r_fifo_row [FIFO_DEPTH];
  logic [COORD_SZ-1:0] r_fifo_col [FIFO_DEPTH];
  logic [c_PTR_W-1:0]  r_wr_ptr, r_rd_ptr;
  logic [c_CNT_W-1:0]  r_count;

  logic                w_on_screen;
  logic                w_full, w_empty;
  logic                w_push, w_drop, w_pop;
  logic [COORD_SZ-1:0] w_head_row, w_head_col;
  logic [ADR_SZ-1:0]   w_lin;
  logic                w_clr_pend;
  logic                w_clr_start, w_clr_done;

  // ---------------------------------------------------------------- input stage
  assign w_on_screen = (dot_row_i < c_SCR_H) && (dot_col_i < c_SCR_W);
  assign w_full      = (r_count == c_FULL);
  assign w_empty     = (r_count == '0);
  // Fullness uses pre-pop occupancy, so a full FIFO drops even when it pops.
  assign w_push      = dot_valid_i && w_on_screen && !w_full;
  assign w_drop      = dot_valid_i && w_on_screen &&  w_full;

  assign w_head_row  = r_fifo_row[r_rd_ptr];
  assign w_head_col  = r_fifo_col[r_rd_ptr];
  assign w_lin       = ADR_SZ'(w_head_row * c_SCR_W + w_head_col);

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_fifo_row[r_wr_ptr] <= dot_row_i;
      r_fifo_col[r_wr_ptr] <= dot_col_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_wr_ptr <= r_wr_ptr + c_PTR_W'(w_push);
      r_rd_ptr <= r_rd_ptr + c_PTR_W'(w_pop);
      r_count  <= r_count + c_CNT_W'(w_push) - c_CNT_W'(w_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_clipped  <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_clipped <= dot_valid_i && !w_on_screen;
      if (w_clr_start) r_overflow <= 1'b0;
      if (w_drop)      r_overflow <= 1'b1;
    end
  end

  // ---------------------------------------------------------------- clear request
`ifdef FB_DOT_WRITER_CLEAR_EN
  logic r_clr_pend;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_clr_pend <= 1'b0;
    end else if (w_clr_done) begin
      r_clr_pend <= 1'b0;
    end else if (clear_i && (r_state != S_CLEAR)) begin
      r_clr_pend <= 1'b1;
    end
  end

  assign w_clr_pend = r_clr_pend;
`else
  logic w_unused_clear;
  assign w_unused_clear = clear_i;
  assign w_clr_pend     = 1'b0;
`endif

  // ---------------------------------------------------------------- write FSM
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state <= S_IDLE;
      r_stb   <= 1'b0;
      r_adr   <= '0;
      r_dat   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_stb   <= w_stb_nxt;
      r_adr   <= w_adr_nxt;
      r_dat   <= w_dat_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_stb_nxt   = r_stb;
    w_adr_nxt   = r_adr;
    w_dat_nxt   = r_dat;
    w_pop       = 1'b0;
    w_clr_start = 1'b0;
    w_clr_done  = 1'b0;
    case (r_state)
      S_IDLE: begin
`ifdef FB_DOT_WRITER_CLEAR_EN
        if (w_clr_pend && w_empty) begin
          w_state_nxt = S_CLEAR;
          w_stb_nxt   = 1'b1;
          w_adr_nxt   = '0;
          w_dat_nxt   = '0;
          w_clr_start = 1'b1;
        end else
`endif
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = S_WRITE;
          w_stb_nxt   = 1'b1;
          w_adr_nxt   = w_lin;
          w_dat_nxt   = '1;
        end
      end
      S_WRITE: begin
        if (mem_ack_i) begin
          // A pending clear breaks the back-to-back chain so IDLE can arbitrate.
          if (!w_empty && !w_clr_pend) begin
            w_pop     = 1'b1;
            w_adr_nxt = w_lin;
            w_dat_nxt = '1;
          end else begin
            w_stb_nxt   = 1'b0;
            w_state_nxt = S_IDLE;
          end
        end
      end
`ifdef FB_DOT_WRITER_CLEAR_EN
      S_CLEAR: begin
        if (mem_ack_i) begin
          if (r_adr == c_PIX_LAST) begin
            w_stb_nxt   = 1'b0;
            w_state_nxt = S_IDLE;
            w_clr_done  = 1'b1;
          end else begin
            w_adr_nxt = r_adr + 1'b1;
          end
        end
      end
`endif
      default: begin
        w_state_nxt = S_IDLE;
        w_stb_nxt   = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------- outputs
  assign mem_stb_o  = r_stb;
  assign mem_adr_o  = r_adr;
  assign mem_dat_o  = r_dat;
  assign clipped_o  = r_clipped;
  assign overflow_o = r_overflow;
  assign busy_o     = !w_empty || r_stb || (r_state != S_IDLE) || w_clr_pend;

endmodule
`default_nettype wire
